// File: rtl/nzcv_gen_unit_pkg.sv
// Shared definitions for the NZCV flag producer and the condition-check unit.
// Holds the ARM data-processing opcode encodings, flag bit positions and the
// packed flag payload type.
package nzcv_gen_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLAG_W = 4;

  // Flag bit indices within the 4-bit NZCV vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // ARM data-processing opcodes, instruction bits 24:21
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Flag payload; field order matches the FLAG_* indices
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/nzcv_gen_unit_if.sv
// ALU-to-flag-unit bus plus the MSR flag-write handshake and flag outputs.
// master: ALU/issue side (drives op and MSR request, observes flags).
// slave : nzcv_gen_unit.
interface nzcv_gen_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic             shifter_carry;
  logic             s_bit;
  logic             cond_pass;
  logic             msr_valid;
  logic [3:0]       msr_flags;
  logic             msr_ready;
  logic [3:0]       nzcv;
  logic             nzcv_updated;
  logic             flags_pending;

  modport master (
    output in_valid, alu_op, op_a, op_b, alu_result, shifter_carry, s_bit,
           cond_pass, msr_valid, msr_flags,
    input  msr_ready, nzcv, nzcv_updated, flags_pending
  );

  modport slave (
    input  in_valid, alu_op, op_a, op_b, alu_result, shifter_carry, s_bit,
           cond_pass, msr_valid, msr_flags,
    output msr_ready, nzcv, nzcv_updated, flags_pending
  );
endinterface

// File: rtl/nzcv_gen_unit_calc.sv
// nzcv_calc: combinational NZCV computation for one data-processing op.
// Ports: alu_op, op_a, op_b, alu_result, shifter_carry, flags_in (current
// NZCV, supplies carry-in and the preserved V) -> flags_c (new NZCV).
module nzcv_calc
  import nzcv_gen_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             shifter_carry,
  input  logic [3:0]       flags_in,
  output nzcv_t            flags_c
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned SW  = WIDTH + 1;
  // 2**WIDTH: a sum at or above this carried out; a difference at or above
  // it wrapped, i.e. borrowed.
  localparam logic [SW-1:0] CARRY_LIM = {1'b1, {WIDTH{1'b0}}};

  logic             cin;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [SW-1:0]    sum;

  assign cin = flags_in[FLAG_C];

  always_comb begin
    flags_c.n = alu_result[MSB];
    flags_c.z = (alu_result == '0);
    flags_c.c = shifter_carry;
    flags_c.v = flags_in[FLAG_V];
    x   = op_a;
    y   = op_b;
    sum = '0;
    unique case (alu_op)
      OP_ADD, OP_CMN, OP_ADC: begin
        sum = {1'b0, op_a} + {1'b0, op_b} + SW'((alu_op == OP_ADC) & cin);
        flags_c.c = (sum >= CARRY_LIM);
        flags_c.v = ~(op_a[MSB] ^ op_b[MSB]) & (op_a[MSB] ^ alu_result[MSB]);
      end
      OP_SUB, OP_CMP, OP_SBC, OP_RSB, OP_RSC: begin
        // Reverse-subtract forms just swap the minuend and subtrahend
        if (alu_op == OP_RSB || alu_op == OP_RSC) begin
          x = op_b;
          y = op_a;
        end
        sum = {1'b0, x} - {1'b0, y}
              - SW'((alu_op == OP_SBC || alu_op == OP_RSC) & ~cin);
        flags_c.c = (sum < CARRY_LIM);
        flags_c.v = (x[MSB] ^ y[MSB]) & (x[MSB] ^ alu_result[MSB]);
      end
      default: ;  // logical ops: C from shifter, V preserved
    endcase
  end

endmodule

// File: rtl/nzcv_gen_unit.sv
// nzcv_gen_unit: producer of the architectural NZCV flags.
// Ports: clk, rst_n (async, active low), bus (slave modport): ALU op input
// stage, MSR flag-write handshake, committed nzcv, nzcv_updated pulse and
// flags_pending.
// An op is registered in S1, its flags are computed from S1 and the current
// nzcv, and committed on the following edge. MSR writes are held off while
// an S1 commit is pending so the older op always lands first.
module nzcv_gen_unit
  import nzcv_gen_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input logic          clk,
  input logic          rst_n,
  nzcv_gen_unit_if.slave bus
);

  // S1 payload
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_r;
  logic             s1_sc;
  // S1 holds a valid op that will commit (valid & S & cond_pass)
  logic             s1_commit;

  logic [3:0] nzcv_q;
  logic       updated_q;
  logic       msr_ready_q;
  logic       msr_fire;
  logic       op_in_commit;
  nzcv_t      calc_flags;

  nzcv_calc #(.WIDTH(WIDTH)) u_calc (
    .alu_op        (s1_op),
    .op_a          (s1_a),
    .op_b          (s1_b),
    .alu_result    (s1_r),
    .shifter_carry (s1_sc),
    .flags_in      (nzcv_q),
    .flags_c       (calc_flags)
  );

  assign op_in_commit = bus.in_valid & bus.s_bit & bus.cond_pass;
  assign msr_fire     = bus.msr_valid & msr_ready_q;

  // S1 datapath capture; contents are don't-care unless s1_commit is set
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      s1_op <= bus.alu_op;
      s1_a  <= bus.op_a;
      s1_b  <= bus.op_b;
      s1_r  <= bus.alu_result;
      s1_sc <= bus.shifter_carry;
    end
  end

  // Control state and the architectural flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_commit   <= 1'b0;
      msr_ready_q <= 1'b1;
      nzcv_q      <= '0;
      updated_q   <= 1'b0;
    end else begin
      s1_commit   <= op_in_commit;
      msr_ready_q <= ~op_in_commit;
      updated_q   <= s1_commit | msr_fire;
      if (s1_commit) begin
        nzcv_q <= calc_flags;
      end else if (msr_fire) begin
        nzcv_q <= bus.msr_flags;
      end
    end
  end

  assign bus.nzcv          = nzcv_q;
  assign bus.nzcv_updated  = updated_q;
  assign bus.flags_pending = s1_commit;
  assign bus.msr_ready     = msr_ready_q;

endmodule

// File: tb/tb_nzcv_gen_unit.sv
// Self-checking bench for nzcv_gen_unit: directed scenarios followed by
// random ops and MSR writes, compared against an arithmetic reference model.
module tb_nzcv_gen_unit;
  import nzcv_gen_unit_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         sc;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nzcv_gen_unit_if #(.WIDTH(W)) bus ();

  nzcv_gen_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: committed flags, last-edge update, ops awaiting commit
  logic [3:0] m_nzcv = 4'b0000;
  logic       m_upd  = 1'b0;
  op_t        m_q[$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flags from ARM semantics, using signed/unsigned integer arithmetic
  function automatic logic [3:0] ref_flags(input op_t o, input logic [3:0] old);
    logic n, z, c, v, cin;
    logic [W-1:0] x, y;
    longint s;
    n   = o.r[W-1];
    z   = (o.r == 0);
    c   = o.sc;
    v   = old[0];
    cin = old[1];
    case (o.op)
      OP_ADD, OP_CMN, OP_ADC: begin
        s = longint'(o.a) + longint'(o.b) + ((o.op == OP_ADC) ? longint'(cin) : 64'sd0);
        c = (s > 64'sh0000_0000_FFFF_FFFF);
        v = (o.a[W-1] == o.b[W-1]) && (o.r[W-1] != o.a[W-1]);
      end
      OP_SUB, OP_CMP, OP_SBC, OP_RSB, OP_RSC: begin
        x = ((o.op == OP_RSB) || (o.op == OP_RSC)) ? o.b : o.a;
        y = ((o.op == OP_RSB) || (o.op == OP_RSC)) ? o.a : o.b;
        s = longint'(x) - longint'(y)
            - (((o.op == OP_SBC) || (o.op == OP_RSC)) ? longint'(!cin) : 64'sd0);
        c = (s >= 0);
        v = (x[W-1] != y[W-1]) && (o.r[W-1] != x[W-1]);
      end
      default: ;
    endcase
    return {n, z, c, v};
  endfunction

  // Advance the reference by one clock edge using the inputs held at the edge
  task automatic model_edge();
    op_t o;
    if (m_q.size() != 0) begin
      o = m_q.pop_front();
      m_nzcv = ref_flags(o, m_nzcv);
      m_upd  = 1'b1;
    end else if (bus.msr_valid) begin
      m_nzcv = bus.msr_flags;
      m_upd  = 1'b1;
    end else begin
      m_upd = 1'b0;
    end
    if (bus.in_valid && bus.s_bit && bus.cond_pass) begin
      o.op = bus.alu_op;
      o.a  = bus.op_a;
      o.b  = bus.op_b;
      o.r  = bus.alu_result;
      o.sc = bus.shifter_carry;
      m_q.push_back(o);
    end
  endtask

  task automatic step(input string tag);
    check_val({tag, "_rdy"}, 32'(bus.msr_ready), 32'(m_q.size() == 0));
    @(posedge clk);
    model_edge();
    #1;
    check_val({tag, "_nzcv"}, 32'(bus.nzcv), 32'(m_nzcv));
    check_val({tag, "_upd"}, 32'(bus.nzcv_updated), 32'(m_upd));
    check_val({tag, "_pend"}, 32'(bus.flags_pending), 32'(m_q.size() != 0));
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] r,
                       input logic sc, input logic s, input logic cp);
    bus.in_valid      = 1'b1;
    bus.alu_op        = op;
    bus.op_a          = a;
    bus.op_b          = b;
    bus.alu_result    = r;
    bus.shifter_carry = sc;
    bus.s_bit         = s;
    bus.cond_pass     = cp;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.msr_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] edges [4];
    edges[0] = 32'h0000_0000;
    edges[1] = 32'h7FFF_FFFF;
    edges[2] = 32'h8000_0000;
    edges[3] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.alu_op = '0; bus.op_a = '0; bus.op_b = '0;
    bus.alu_result = '0; bus.shifter_carry = 1'b0; bus.s_bit = 1'b0;
    bus.cond_pass = 1'b0; bus.msr_valid = 1'b0; bus.msr_flags = '0;

    // Reset state
    #12;
    check_val("rst_nzcv", 32'(bus.nzcv), 32'h0);
    check_val("rst_upd", 32'(bus.nzcv_updated), 32'h0);
    check_val("rst_pend", 32'(bus.flags_pending), 32'h0);
    check_val("rst_rdy", 32'(bus.msr_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDS overflow to zero: Z and C
    drive(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b1);
    step("add0");
    check_val("add0_pend1", 32'(bus.flags_pending), 32'h1);
    idle();
    step("add0c");
    check_val("add0_flags", 32'(bus.nzcv), 32'h6);
    check_val("add0_pulse", 32'(bus.nzcv_updated), 32'h1);
    check_val("add0_pend0", 32'(bus.flags_pending), 32'h0);
    step("add0d");
    check_val("add0_pulse_end", 32'(bus.nzcv_updated), 32'h0);

    // Signed overflow, then CMP borrow
    drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    step("addv");
    idle();
    step("addvc");
    check_val("addv_flags", 32'(bus.nzcv), 32'h9);
    drive(OP_CMP, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);
    step("cmp");
    idle();
    step("cmpc");
    check_val("cmp_flags", 32'(bus.nzcv), 32'h8);

    // Back-to-back ADDS then ADCS: ADC sees the fresh carry
    drive(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b1);
    step("b2b0");
    drive(OP_ADC, 32'h0, 32'h0, 32'h1, 1'b0, 1'b1, 1'b1);
    step("b2b1");
    check_val("b2b_first", 32'(bus.nzcv), 32'h6);
    check_val("b2b_pulse1", 32'(bus.nzcv_updated), 32'h1);
    idle();
    step("b2b2");
    check_val("b2b_final", 32'(bus.nzcv), 32'h0);
    check_val("b2b_pulse2", 32'(bus.nzcv_updated), 32'h1);

    // MSR sets V, MOVS keeps it, failed-condition MOVS has no effect
    bus.msr_valid = 1'b1;
    bus.msr_flags = 4'b0001;
    step("msrv");
    idle();
    check_val("msrv_flags", 32'(bus.nzcv), 32'h1);
    drive(OP_MOV, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    step("mov");
    idle();
    step("movc");
    check_val("mov_flags", 32'(bus.nzcv), 32'h7);
    drive(OP_MOV, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step("movn");
    idle();
    step("movnc");
    check_val("movn_flags", 32'(bus.nzcv), 32'h7);
    check_val("movn_nopulse", 32'(bus.nzcv_updated), 32'h0);

    // MSR waits behind a pending SUBS
    drive(OP_SUB, 32'hA, 32'h3, 32'h7, 1'b0, 1'b1, 1'b1);
    step("subm");
    bus.in_valid  = 1'b0;
    bus.msr_valid = 1'b1;
    bus.msr_flags = 4'b1111;
    check_val("subm_blocked", 32'(bus.msr_ready), 32'h0);
    step("submc");
    check_val("subm_flags", 32'(bus.nzcv), 32'h2);
    step("submm");
    check_val("subm_msr", 32'(bus.nzcv), 32'hF);
    idle();

    // Reset with an op sitting in S1
    drive(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b1);
    step("rsto");
    #1 rst_n = 1'b0;
    #1;
    check_val("rsto_nzcv", 32'(bus.nzcv), 32'h0);
    check_val("rsto_pend", 32'(bus.flags_pending), 32'h0);
    m_nzcv = 4'b0000;
    m_upd  = 1'b0;
    m_q.delete();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step("rstr");
    check_val("rstr_nzcv", 32'(bus.nzcv), 32'h0);
    check_val("rstr_nopulse", 32'(bus.nzcv_updated), 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b, r;
      op = 4'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      case (op)
        OP_ADD, OP_CMN: r = a + b;
        OP_ADC:         r = a + b + W'(m_nzcv[1]);
        OP_SUB, OP_CMP: r = a - b;
        OP_SBC:         r = a - b - W'(!m_nzcv[1]);
        OP_RSB:         r = b - a;
        OP_RSC:         r = b - a - W'(!m_nzcv[1]);
        default:        r = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      endcase
      drive(op, a, b, r, 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) != 0));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.msr_valid = ($urandom_range(0, 6) == 0);
      bus.msr_flags = 4'($urandom);
      step("rnd");
    end
    idle();
    step("tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nzcv_gen_unit.md
Name: nzcv_gen_unit

Overview:
Producer side of the NZCV condition-flag interface.
- Takes each data-processing result from the ALU and computes N, Z, C and V according to the ARM opcode.
- Holds the architectural NZCV register and commits new flags when the S bit is set and the instruction's condition passed.
- Also accepts direct flag writes (MSR flags field).
- Drives the committed flags to the condition-check unit, plus a pending indication so issue logic can stall condition evaluation.

Parameters:
WIDTH, 32, datapath width of operands and ALU result.

Ports:
clk  input  1  system clock, all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  data-processing op presented this cycle. Accepted every cycle; there is no backpressure.
alu_op  input  4  ARM data-processing opcode, instruction bits 24:21.
op_a  input  WIDTH  first operand (Rn).
op_b  input  WIDTH  shifted second operand.
alu_result  input  WIDTH  ALU result for this op.
shifter_carry  input  1  barrel-shifter carry-out.
s_bit  input  1  instruction S bit.
cond_pass  input  1  the op's condition evaluated true.
msr_valid  input  1  direct flag-write request.
msr_flags  input  4  NZCV value for the MSR write.
msr_ready  output  1  MSR accepted this cycle. Equal to !flags_pending.
nzcv  output  4  committed flags: [3]=N, [2]=Z, [1]=C, [0]=V.
nzcv_updated  output  1  one-cycle pulse in the cycle after nzcv changed source (any commit, even if the value is equal).
flags_pending  output  1  a flag-setting op is in flight and nzcv is stale.

Behaviour:
Reset and pipeline
- Reset (async, rst_n low) clears nzcv=0000, nzcv_updated=0, stage-1 valid=0, flags_pending=0.
- Reset mid-operation discards the in-flight op.
- Stage 1 (S1): on a rising edge with in_valid=1, register alu_op, op_a, op_b, alu_result, shifter_carry and commit = s_bit & cond_pass. S1 valid <= in_valid.
- Stage 2: flags are computed combinationally from the S1 register and the current nzcv. On the next edge nzcv <= computed if S1 valid & commit.
- Latency: flags visible on nzcv 2 edges after in_valid.
- Back-to-back flag-setting ops are supported at 1 per cycle. The ADC/SBC/RSC carry-in is the current nzcv[1], which already holds the previous op's result.

flags_pending
- flags_pending = S1 valid & S1 commit.

Flag rules
- Msb means bit WIDTH-1 in all rules.
- N = alu_result msb for all opcodes.
- Z = (alu_result == 0) for all opcodes.
- Logical ops (AND 0000, EOR 0001, TST 1000, TEQ 1001, ORR 1100, MOV 1101, BIC 1110, MVN 1111): C = shifter_carry; V unchanged.
- ADD 0100, CMN 1011: compute the WIDTH+1-bit sum op_a+op_b. C = bit WIDTH; V = ~(a^b)&(a^r) on msbs.
- ADC 0101: as ADD, plus carry-in Cin.
- SUB 0010, CMP 1010: C = (op_a >= op_b) unsigned; V = (a^b)&(a^r) msbs.
- SBC 0110: as SUB, but C = no-borrow of a - b - !Cin.
- RSB 0011 and RSC 0111: as SUB/SBC with a and b swapped.
- The internal sum is used only for C. N/Z/V use alu_result.

MSR arbitration
- An MSR is accepted when msr_valid & msr_ready: nzcv <= msr_flags on that edge.
- If the S1 commit is also pending, msr_ready is 0, so the MSR waits and the older op commits first.
- MSR and an in_valid op in the same cycle: the MSR commits this edge; the op commits one edge later and overwrites.

Other rules
- Ops with s_bit=0 or cond_pass=0 traverse S1 with no effect and no nzcv_updated pulse.
- nzcv_updated is registered: high exactly one cycle after each commit edge (op or MSR).

Decomposition:
- Shared package: opcode constants (OP_AND..OP_MVN) and flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), also usable by the condition-check unit.
- One sub-module, nzcv_calc: purely combinational opcode/operands/result/Cin -> NZCV.
- The top level holds the S1 register, nzcv register, MSR arbitration and outputs.

Test Plan:
- Reset, then ADD S a=0xFFFFFFFF b=1 r=0 -> 2 edges later nzcv=0110 (Z,C); nzcv_updated pulses once; flags_pending high for 1 cycle.
- ADD S a=0x7FFFFFFF b=1 r=0x80000000 -> nzcv=1001. Then CMP a=3 b=5 r=0xFFFFFFFE -> nzcv=1000 (N, C=0 borrow, V=0).
- ADDS 0xFFFFFFFF+1 back-to-back with ADCS a=0 b=0 r=1 -> ADC sees Cin=1; final nzcv=0000; two nzcv_updated pulses on consecutive cycles.
- MOVS r=0 with shifter_carry=1 and prior V=1 -> nzcv=0111 (V preserved). Same op with cond_pass=0 -> nzcv unchanged, no pulse.
- SUBS in S1 plus msr_valid flags=1111 -> msr_ready=0 that cycle; SUB flags commit, then next edge nzcv=1111.
- rst_n low while an op is in S1 -> nzcv=0000 and flags_pending=0 immediately; no commit after release.
